// File: rtl/axi_lite_to_obi.sv
// AXI-Lite slave to OBI master bridge, one transaction in flight; write/read alternate on collision.
// Latency: accept c0, obi_req c1, B/R valid c3 minimum; AXI readies only in IDLE, responses held until accepted.
module axi_lite_to_obi #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   axi_awaddr_i,
  input  logic                   axi_awvalid_i,
  output logic                   axi_awready_o,
  input  logic [DataWidth-1:0]   axi_wdata_i,
  input  logic [DataWidth/8-1:0] axi_wstrb_i,
  input  logic                   axi_wvalid_i,
  output logic                   axi_wready_o,
  output logic [1:0]             axi_bresp_o,
  output logic                   axi_bvalid_o,
  input  logic                   axi_bready_i,
  input  logic [AddrWidth-1:0]   axi_araddr_i,
  input  logic                   axi_arvalid_i,
  output logic                   axi_arready_o,
  output logic [DataWidth-1:0]   axi_rdata_o,
  output logic [1:0]             axi_rresp_o,
  output logic                   axi_rvalid_o,
  input  logic                   axi_rready_i,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [2:0] {
    IDLE, WREQ, WWAIT, BRESP, RREQ, RWAIT, RRESP
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   be_q;
  logic                   we_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   rd_pref_q;

  logic wr_elig, rd_elig;
  logic do_wr, do_rd;
  logic wr_rsp, rd_rsp;

  assign wr_elig = axi_awvalid_i && axi_wvalid_i;
  assign rd_elig = axi_arvalid_i;

  always_comb begin
    state_d      = state_q;
    do_wr        = 1'b0;
    do_rd        = 1'b0;
    wr_rsp       = 1'b0;
    rd_rsp       = 1'b0;
    obi_req_o    = 1'b0;
    axi_bvalid_o = 1'b0;
    axi_rvalid_o = 1'b0;
    case (state_q)
      IDLE: begin
        // rd_pref_q set means the last grant went to a write
        do_wr = wr_elig && (!rd_elig || !rd_pref_q);
        do_rd = rd_elig && !do_wr;
        if (do_wr) begin
          state_d = WREQ;
        end else if (do_rd) begin
          state_d = RREQ;
        end
      end
      WREQ: begin
        obi_req_o = 1'b1;
        if (obi_gnt_i) state_d = WWAIT;
      end
      WWAIT: begin
        if (obi_rvalid_i) begin
          wr_rsp  = 1'b1;
          state_d = BRESP;
        end
      end
      BRESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) state_d = IDLE;
      end
      RREQ: begin
        obi_req_o = 1'b1;
        if (obi_gnt_i) state_d = RWAIT;
      end
      RWAIT: begin
        if (obi_rvalid_i) begin
          rd_rsp  = 1'b1;
          state_d = RRESP;
        end
      end
      RRESP: begin
        axi_rvalid_o = 1'b1;
        if (axi_rready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      rd_pref_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_wr) begin
        addr_q    <= axi_awaddr_i;
        wdata_q   <= axi_wdata_i;
        be_q      <= axi_wstrb_i;
        we_q      <= 1'b1;
        rd_pref_q <= 1'b1;
      end else if (do_rd) begin
        addr_q    <= axi_araddr_i;
        be_q      <= '1;
        we_q      <= 1'b0;
        rd_pref_q <= 1'b0;
      end
      if (wr_rsp) bresp_q <= obi_err_i ? 2'b10 : 2'b00;
      if (rd_rsp) begin
        rresp_q <= obi_err_i ? 2'b10 : 2'b00;
        rdata_q <= obi_rdata_i;
      end
    end
  end

  assign axi_awready_o = do_wr;
  assign axi_wready_o  = do_wr;
  assign axi_arready_o = do_rd;
  assign axi_bresp_o   = bresp_q;
  assign axi_rresp_o   = rresp_q;
  assign axi_rdata_o   = rdata_q;
  assign obi_addr_o    = addr_q;
  assign obi_wdata_o   = wdata_q;
  assign obi_be_o      = be_q;
  assign obi_we_o      = we_q;

endmodule

// File: tb/tb_axi_lite_to_obi.sv
// Directed bench for axi_lite_to_obi: write, delayed-grant read, collisions, errors, stalls, reset.
module tb_axi_lite_to_obi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] axi_awaddr_i;
  logic        axi_awvalid_i;
  logic        axi_awready_o;
  logic [31:0] axi_wdata_i;
  logic [3:0]  axi_wstrb_i;
  logic        axi_wvalid_i;
  logic        axi_wready_o;
  logic [1:0]  axi_bresp_o;
  logic        axi_bvalid_o;
  logic        axi_bready_i;
  logic [31:0] axi_araddr_i;
  logic        axi_arvalid_i;
  logic        axi_arready_o;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic        axi_rvalid_o;
  logic        axi_rready_i;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_to_obi #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .axi_awaddr_i(axi_awaddr_i), .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wvalid_i(axi_wvalid_i),
    .axi_wready_o(axi_wready_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
    .axi_bready_i(axi_bready_i), .axi_araddr_i(axi_araddr_i), .axi_arvalid_i(axi_arvalid_i),
    .axi_arready_o(axi_arready_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i), .obi_req_o(obi_req_o),
    .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
    .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .obi_err_i(obi_err_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the first REQ cycle; holds gnt off for gdly cycles, then returns one response.
  task automatic obi_serve(input string tag, input int gdly, input logic exp_we,
                           input logic [31:0] exp_addr, input logic [31:0] rd, input logic err);
    for (int i = 0; i < gdly; i++) begin
      chk({tag, "_req_hold"}, 64'(obi_req_o), 64'd1);
      chk({tag, "_addr_hold"}, 64'(obi_addr_o), 64'(exp_addr));
      tick();
    end
    chk({tag, "_req"}, 64'(obi_req_o), 64'd1);
    chk({tag, "_addr"}, 64'(obi_addr_o), 64'(exp_addr));
    chk({tag, "_we"}, 64'(obi_we_o), 64'(exp_we));
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    chk({tag, "_req_low"}, 64'(obi_req_o), 64'd0);
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = rd;
    obi_err_i    = err;
    tick();
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    axi_awaddr_i = '0; axi_awvalid_i = 1'b0; axi_wdata_i = '0; axi_wstrb_i = '0;
    axi_wvalid_i = 1'b0; axi_bready_i = 1'b0; axi_araddr_i = '0; axi_arvalid_i = 1'b0;
    axi_rready_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0;
    obi_err_i = 1'b0;
    do_reset();

    chk("rst_bvalid", 64'(axi_bvalid_o), 64'd0);
    chk("rst_rvalid", 64'(axi_rvalid_o), 64'd0);
    chk("rst_req", 64'(obi_req_o), 64'd0);
    chk("rst_addr", 64'(obi_addr_o), 64'd0);
    chk("rst_rdata", 64'(axi_rdata_o), 64'd0);

    // Basic write: gnt with req, rvalid next, bvalid cycle 3
    axi_awaddr_i = 32'h1000; axi_wdata_i = 32'hDEADBEEF; axi_wstrb_i = 4'hF;
    axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1;
    #1;
    chk("wr_awready", 64'(axi_awready_o), 64'd1);
    chk("wr_wready", 64'(axi_wready_o), 64'd1);
    chk("wr_arready", 64'(axi_arready_o), 64'd0);
    tick();
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    chk("wr_be", 64'(obi_be_o), 64'hF);
    chk("wr_wdata", 64'(obi_wdata_o), 64'hDEADBEEF);
    obi_serve("wr", 0, 1'b1, 32'h1000, 32'h0, 1'b0);
    chk("wr_bvalid", 64'(axi_bvalid_o), 64'd1);
    chk("wr_bresp", 64'(axi_bresp_o), 64'd0);
    axi_bready_i = 1'b1;
    tick();
    axi_bready_i = 1'b0;
    chk("wr_bvalid_done", 64'(axi_bvalid_o), 64'd0);

    // Read with grant delayed 3 cycles: req held 4 cycles
    axi_araddr_i = 32'h2004; axi_arvalid_i = 1'b1;
    #1;
    chk("rd_arready", 64'(axi_arready_o), 64'd1);
    tick();
    axi_arvalid_i = 1'b0;
    chk("rd_be", 64'(obi_be_o), 64'hF);
    obi_serve("rd", 3, 1'b0, 32'h2004, 32'h12345678, 1'b0);
    chk("rd_rvalid", 64'(axi_rvalid_o), 64'd1);
    chk("rd_rdata", 64'(axi_rdata_o), 64'h12345678);
    chk("rd_rresp", 64'(axi_rresp_o), 64'd0);
    axi_rready_i = 1'b1;
    tick();
    axi_rready_i = 1'b0;
    chk("rd_rvalid_done", 64'(axi_rvalid_o), 64'd0);
    chk("rd_addr_retain", 64'(obi_addr_o), 64'h2004);

    // Collisions from reset: write first, then read, then write
    do_reset();
    axi_awaddr_i = 32'h3000; axi_wdata_i = 32'hA5A5A5A5; axi_wstrb_i = 4'h3;
    axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1;
    axi_araddr_i = 32'h4000; axi_arvalid_i = 1'b1;
    #1;
    chk("c1_awready", 64'(axi_awready_o), 64'd1);
    chk("c1_arready", 64'(axi_arready_o), 64'd0);
    tick();
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    chk("c1_be", 64'(obi_be_o), 64'h3);
    obi_serve("c1", 0, 1'b1, 32'h3000, 32'h0, 1'b0);
    chk("c1_bvalid", 64'(axi_bvalid_o), 64'd1);
    axi_bready_i = 1'b1;
    tick();
    axi_bready_i = 1'b0;

    axi_awaddr_i = 32'h5000; axi_wdata_i = 32'h11223344; axi_wstrb_i = 4'hC;
    axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1;
    #1;
    chk("c2_arready", 64'(axi_arready_o), 64'd1);
    chk("c2_awready", 64'(axi_awready_o), 64'd0);
    tick();
    axi_arvalid_i = 1'b0;
    chk("c2_be", 64'(obi_be_o), 64'hF);
    obi_serve("c2", 1, 1'b0, 32'h4000, 32'hCAFEF00D, 1'b1);
    chk("c2_rvalid", 64'(axi_rvalid_o), 64'd1);
    chk("c2_rdata", 64'(axi_rdata_o), 64'hCAFEF00D);
    chk("c2_rresp_err", 64'(axi_rresp_o), 64'h2);
    axi_rready_i = 1'b1;
    tick();
    axi_rready_i = 1'b0;

    axi_araddr_i = 32'h6000; axi_arvalid_i = 1'b1;
    #1;
    chk("c3_awready", 64'(axi_awready_o), 64'd1);
    chk("c3_arready", 64'(axi_arready_o), 64'd0);
    tick();
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    chk("c3_wdata", 64'(obi_wdata_o), 64'h11223344);
    obi_serve("c3", 0, 1'b1, 32'h5000, 32'h0, 1'b1);

    // B stalled 5 cycles while AR waits
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", 64'(axi_bvalid_o), 64'd1);
      chk("stall_bresp", 64'(axi_bresp_o), 64'h2);
      chk("stall_arready", 64'(axi_arready_o), 64'd0);
      tick();
    end
    axi_bready_i = 1'b1;
    #1;
    chk("stall_bvalid_hs", 64'(axi_bvalid_o), 64'd1);
    tick();
    axi_bready_i = 1'b0;
    chk("after_b_arready", 64'(axi_arready_o), 64'd1);
    tick();
    axi_arvalid_i = 1'b0;

    // Reset while waiting for the read response; late rvalid must be dropped
    chk("rst_mid_req", 64'(obi_req_o), 64'd1);
    chk("rst_mid_addr", 64'(obi_addr_o), 64'h6000);
    obi_gnt_i = 1'b1;
    tick();
    obi_gnt_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hBAD0BAD0; obi_err_i = 1'b1;
    tick();
    obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
    chk("late_rvalid", 64'(axi_rvalid_o), 64'd0);
    chk("late_rdata", 64'(axi_rdata_o), 64'd0);
    chk("late_rresp", 64'(axi_rresp_o), 64'd0);
    chk("late_req", 64'(obi_req_o), 64'd0);
    chk("late_addr", 64'(obi_addr_o), 64'd0);
    tick();
    chk("late_rvalid2", 64'(axi_rvalid_o), 64'd0);

    // AW without W is never accepted
    axi_awaddr_i = 32'h7000; axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b0;
    #1;
    chk("aw_only_awready", 64'(axi_awready_o), 64'd0);
    tick();
    chk("aw_only_req", 64'(obi_req_o), 64'd0);
    chk("aw_only_awready2", 64'(axi_awready_o), 64'd0);
    axi_awvalid_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
